simon_pad: RTL
==============

SIMON_PAD -- requirements
Module: simon_pad

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 3, meaning consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have parameter FLASH, default 15, meaning cycles the player-press LED echo stays lit after the pulse.
REQ-003 SHALL have parameter BLINK, default 15, meaning half-period in cycles of the game-over LED blink.
REQ-004 SHALL have port clk, input, 1 bit, the single 60 Hz system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port btn, input, 4 bits, raw asynchronous push buttons, active-high, bit i means colour i.
REQ-007 SHALL have port simonTurn, input, 1 bit, 1 while Simon plays the sequence.
REQ-008 SHALL have port simonNum, input, 2 bits, the colour Simon is currently showing.
REQ-009 SHALL have port simonPressed, input, 1 bit, 1 while Simon's colour is lit.
REQ-010 SHALL have port gameOver, input, 1 bit, 1 when the game has ended.
REQ-011 SHALL have port playerNum, output, 2 bits, the colour of the last accepted player press.
REQ-012 SHALL have port playerPressed, output, 1 bit, a single-cycle pulse per accepted press.
REQ-013 SHALL have port led, output, 4 bits, colour lamps, active-high.

Function
REQ-014 SHALL pass btn through a 2-flop synchronizer before any other use.
REQ-015 SHALL keep, per bit, a debounced level that toggles only after the synchronized bit differs from it for DEBOUNCE consecutive cycles; any agreeing cycle SHALL clear that bit's counter.
REQ-016 SHALL implement FSM states IDLE, PULSE, HELD.
REQ-017 IDLE -> PULSE SHALL occur when the debounced vector is exactly one-hot, simonTurn=0 and gameOver=0.
REQ-018 IDLE -> HELD SHALL occur when any debounced bit is 1 and the REQ-017 conditions are not met: multi-press, press during simonTurn=1, or press during gameOver=1.
REQ-019 In PULSE, playerPressed SHALL be 1 for exactly that one cycle and playerNum SHALL equal the one-hot index; the next state SHALL be HELD.
REQ-020 The total latency from a clean synchronized edge to the playerPressed cycle SHALL be DEBOUNCE+1 cycles.
REQ-021 HELD -> IDLE SHALL occur only when all debounced bits are 0; a second button added while in HELD SHALL never generate a pulse.
REQ-022 playerNum SHALL hold its last value between pulses.
REQ-023 Any button held across a simonTurn 1->0 edge SHALL produce no pulse until all buttons are released and then pressed again.
REQ-024 The led priority SHALL be, first match wins:
- gameOver=1: all four lamps toggle together every BLINK cycles, starting lit on the first gameOver cycle.
- simonTurn=1: led = onehot(simonNum) when simonPressed=1, else 0.
- echo timer nonzero, or FSM in HELD after a pulse with the same button still down: led = onehot(playerNum).
- otherwise: led = 0.
REQ-025 The echo timer SHALL load FLASH in the PULSE cycle, decrement to 0, and saturate at 0; a new pulse SHALL reload it.
REQ-026 The blink counter SHALL be cleared whenever gameOver=0.
REQ-027 gameOver rising SHALL force the FSM to HELD when any button is down, otherwise to IDLE; no pulse SHALL be issued while gameOver=1.

Reset
REQ-028 While reset=0, all of the following SHALL be 0: synchronizer flops, debounced levels, debounce counters, echo timer, blink counter, playerNum, playerPressed and led; the FSM SHALL be in IDLE.
REQ-029 Reset deassertion mid-press SHALL be treated as a fresh press: a held button produces one pulse DEBOUNCE+3 cycles later, provided simonTurn=0 and gameOver=0.
REQ-030 Reset SHALL take effect immediately, without a clock edge, including in the middle of a PULSE cycle.

Verification
REQ-031 With simonTurn=0 and gameOver=0, btn=0100 held 20 cycles SHALL give exactly one playerPressed pulse, DEBOUNCE+3=6 cycles after the btn edge, with playerNum=2 and led=0100 for 15 cycles.
REQ-032 A btn[1] bounce of 1,0,1,0 on successive cycles followed by a 10-cycle hold SHALL give exactly one pulse with playerNum=1.
REQ-033 btn=0011 pressed simultaneously SHALL give no pulse; after full release, btn=1000 SHALL give a pulse with playerNum=3.
REQ-034 btn[0] pressed while simonTurn=1 and held through simonTurn 1->0 SHALL give no pulse; release then re-press SHALL give one pulse with playerNum=0.
REQ-035 simonTurn=1, simonNum=3, simonPressed toggling SHALL give led alternating between 1000 and 0000; gameOver=1 SHALL give led toggling between 1111 and 0000 every 15 cycles, with presses ignored.
REQ-036 reset driven low asynchronously between clock edges SHALL zero all outputs at once; btn held through reset release SHALL give one pulse.

Source files
------------

// File: rtl/simon_pad.sv
// Player-side button pad for a Simon game: synchronizes and debounces four buttons,
// issues one pulse per clean single press, and drives the colour lamps.
module simon_pad #(
   parameter int DEBOUNCE = 3,
   parameter int FLASH    = 15,
   parameter int BLINK    = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn,
   input  logic       simonTurn,
   input  logic [1:0] simonNum,
   input  logic       simonPressed,
   input  logic       gameOver,
   output logic [1:0] playerNum,
   output logic       playerPressed,
   output logic [3:0] led
);

   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int EW = $clog2(FLASH + 1);
   localparam int BW = $clog2(BLINK + 1);

   typedef enum logic [1:0] {IDLE, PULSE, HELD} state_t;

   state_t               state, state_next;
   logic [3:0]           sync_p0, sync_p1;
   logic [3:0]           deb;
   logic [3:0][DW-1:0]   deb_cnt;
   logic [EW-1:0]        echo;
   logic                 echo_hold;
   logic [BW-1:0]        blink_cnt;
   logic                 blink_off;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0) && ((v & (v - 4'b1)) == 4'b0);
   endfunction

   function automatic logic [1:0] oh_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++)
         if (v[i]) idx = 2'(i);
      return idx;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] n);
      return 4'b1 << n;
   endfunction

   // Stage p0/p1: two-flop synchronizer on the raw buttons
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
      end
   end

   // Debounce: a level flips only after DEBOUNCE consecutive disagreeing samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb     <= '0;
         deb_cnt <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync_p1[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DW'(DEBOUNCE - 1)) begin
               deb[i]     <= sync_p1[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      if (gameOver) begin
         state_next = (|deb) ? HELD : IDLE;
      end else begin
         case (state)
            IDLE:    if (is_onehot(deb) && !simonTurn) state_next = PULSE;
                     else if (|deb)                    state_next = HELD;
            PULSE:   state_next = HELD;
            HELD:    if (deb == 4'b0) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Echo timer loads as PULSE is entered so the lamp is already lit in the pulse cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         playerNum <= '0;
         echo      <= '0;
         echo_hold <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next == PULSE) begin
            playerNum <= oh_index(deb);
            echo      <= EW'(FLASH);
            echo_hold <= 1'b1;
         end else begin
            if (echo != '0) echo <= echo - 1'b1;
            if (state == IDLE) echo_hold <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (!gameOver) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (blink_cnt == BW'(BLINK - 1)) begin
         blink_cnt <= '0;
         blink_off <= ~blink_off;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   assign playerPressed = (state == PULSE);

   // Lamps decode live inputs, so they are gated by reset to stay dark during reset
   always_comb begin
      led = 4'b0;
      if (!reset)
         led = 4'b0;
      else if (gameOver)
         led = {4{~blink_off}};
      else if (simonTurn)
         led = simonPressed ? onehot(simonNum) : 4'b0;
      else if ((echo != '0) || (state == HELD && echo_hold && deb[playerNum]))
         led = onehot(playerNum);
   end

endmodule
